pipe_ctrl_unit: RTL
===================

Name: pipe_ctrl_unit

Overview:
- Consumer side of the hazard detection unit. It takes `data_hazard`/`PC_hazard` plus branch/halt status and sequences pipeline stalls, flushes and bubbles.
- For returns it generates the `PC_update` pulse, which clears `PC_hazard` in the hazard unit.
- It keeps a saturating stall-cycle performance counter.
- It sits beside the IF/ID and ID/EX pipeline registers and the PC register.

Parameters:
- RET_LAT, 3: cycles from a return being detected until the return target is valid. Legal range 1..7.
- FLUSH_CYC, 1: cycles `IF_ID_flush` is held after a taken branch. Legal range 1..7.
- CNT_W, 16: width of `stall_count`.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data_hazard  in  1  from hazard unit, combinational
- PC_hazard  in  1  from hazard unit; high while a return target is pending
- branch_taken  in  1  EX stage resolved a taken branch this cycle
- halt  in  1  HLT instruction reached ID
- PC_stall  out  1  hold PC
- IF_ID_stall  out  1  hold IF/ID register
- IF_ID_flush  out  1  zero IF/ID contents (NOP)
- ID_EX_bubble  out  1  load NOP into ID/EX
- PC_update  out  1  one-cycle pulse: return target ready, clears PC_hazard
- halted  out  1  core halted (sticky)
- stall_count  out  CNT_W  saturating count of PC_stall cycles

Behaviour:
- Reset (async, rst=1):
  - state=RUN, internal down-counter=0, `stall_count`=0.
  - All 1-bit outputs are 0 while rst is high and after it is released until the first qualifying input.
- States: RUN, RET_WAIT, FLUSH, HALTED.
- State encoding is registered. All outputs except `stall_count` are combinational from state, counter and inputs, so stalls act in the same cycle the hazard appears.
- RUN output/transition priority, highest first:
  - halt: `PC_stall`=`IF_ID_stall`=`ID_EX_bubble`=1. Next state HALTED.
  - branch_taken:
    - `IF_ID_flush`=`ID_EX_bubble`=1; no stall.
    - Next state FLUSH with counter=FLUSH_CYC-1 if FLUSH_CYC>1, else RUN.
    - `data_hazard`/`PC_hazard` are ignored this cycle, since they belong to a wrong-path instruction.
  - PC_hazard: `PC_stall`=`IF_ID_stall`=`ID_EX_bubble`=1. Next state RET_WAIT, counter=RET_LAT.
  - data_hazard: `PC_stall`=`IF_ID_stall`=`ID_EX_bubble`=1. Stay in RUN. Data stall is re-evaluated every cycle and has no state.
  - none of the above: all outputs 0.
- RET_WAIT:
  - `PC_stall`=`IF_ID_stall`=`ID_EX_bubble`=1 every cycle.
  - Counter decrements each cycle.
  - When counter==1: `PC_update`=1, `IF_ID_flush`=1, `PC_stall`=0 (new target loads). Next state RUN.
  - All hazard and branch inputs are ignored.
  - halt is ignored in RET_WAIT; it is re-sampled in RUN.
  - Timing: return detected at cycle T → `PC_update` at T+RET_LAT → RUN at T+RET_LAT+1.
- FLUSH:
  - `IF_ID_flush`=1; no stall.
  - Counter decrements; exit to RUN when counter reaches 1.
  - A branch_taken arriving in FLUSH reloads counter=FLUSH_CYC-1. If FLUSH_CYC==1 that branch is handled in RUN only.
- HALTED:
  - `halted`=1, `PC_stall`=`IF_ID_stall`=`ID_EX_bubble`=1.
  - Sticky until reset; all inputs are ignored.
- stall_count:
  - Registered; increments at each rising edge where `PC_stall`=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Reset mid-operation: any state returns to RUN asynchronously, counter=0. A `PC_update` pending in RET_WAIT is dropped.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum (RUN, RET_WAIT, FLUSH, HALTED; 2-bit)
  - the RET_LAT/FLUSH_CYC legal-range constants, so the hazard unit and testbench reference the same encoding.
- One sub-module: sat_counter (parameter W; ports clk, rst, inc, count), instantiated for `stall_count`.
- The FSM and down-counter live in the top module.

Test Plan:
- Data stall: data_hazard=1 for 2 cycles in RUN, nothing else asserted → `PC_stall`=`IF_ID_stall`=`ID_EX_bubble`=1 both cycles and 0 after; `stall_count`=2.
- Return, RET_LAT=3: PC_hazard rises at T and stays high →
  - stalls at T..T+2
  - `PC_update`=`IF_ID_flush`=1 and `PC_stall`=0 at T+3
  - state RUN at T+4
  - `stall_count`=3.
- Branch beats hazard: branch_taken=1 together with data_hazard=1 and PC_hazard=1 → `IF_ID_flush`=`ID_EX_bubble`=1, `PC_stall`=0, state stays RUN (FLUSH_CYC=1); `stall_count` unchanged.
- Halt: halt=1 one cycle → `halted`=1 from the next cycle and held for 20 cycles with all inputs toggled; `stall_count` increments every cycle.
- Reset mid-return: assert rst at T+1 of RET_WAIT → outputs 0 immediately, `stall_count`=0; no `PC_update` pulse after release.
- Saturation, CNT_W=4: hold data_hazard for 20 cycles → `stall_count` sticks at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
// The hazard unit, the control unit and the testbench all import this so the
// state encoding and the legal latency range come from one place.
package pipe_ctrl_pkg;

  // Control FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  // Legal range for RET_LAT and FLUSH_CYC.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;

  // Width of the internal down-counter; it must hold LAT_MAX.
  localparam int LAT_W = 3;

  // True when a latency parameter lies in the supported range.
  function automatic logic lat_in_range(input int v);
    return (v >= LAT_MIN) && (v <= LAT_MAX);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset, clears count
//   inc   - increment request, sampled on the rising clock edge
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MAX_VAL)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: consumes hazard/branch/halt status and sequences
// PC and IF/ID stalls, IF/ID flushes and ID/EX bubbles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   data_hazard       - load-use style hazard, stalls while high
//   PC_hazard         - return target pending, starts a RET_LAT wait
//   branch_taken      - EX resolved a taken branch, flushes wrong path
//   halt              - HLT in ID, stops the core until reset
//   PC_stall          - hold PC
//   IF_ID_stall       - hold IF/ID register
//   IF_ID_flush       - load NOP into IF/ID
//   ID_EX_bubble      - load NOP into ID/EX
//   PC_update         - one-cycle pulse when the return target is valid
//   halted            - core halted (sticky until reset)
//   stall_count       - saturating count of PC_stall cycles
// All 1-bit outputs are combinational from state, counter and inputs so a
// hazard stalls the pipe in the same cycle it appears.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int RET_LAT   = 3,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_hazard,
  input  logic             PC_hazard,
  input  logic             branch_taken,
  input  logic             halt,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             PC_update,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [LAT_W-1:0] RET_LOAD   = LAT_W'(RET_LAT);
  localparam logic [LAT_W-1:0] FLUSH_LOAD = LAT_W'(FLUSH_CYC - 1);
  // With a single flush cycle the branch cycle itself is the whole flush,
  // so there is no FLUSH state to visit.
  localparam logic             USE_FLUSH  = (FLUSH_CYC > 1);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    PC_update    = 1'b0;
    halted       = 1'b0;

    // Outputs stay quiet during reset even if hazard inputs are high.
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (halt) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
            state_d      = HALTED;
          end else if (branch_taken) begin
            // Hazards this cycle belong to the wrong path and are dropped.
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            if (USE_FLUSH) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_LOAD;
            end
          end else if (PC_hazard) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
            state_d      = RET_WAIT;
            cnt_d        = RET_LOAD;
          end else if (data_hazard) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
          end
        end

        RET_WAIT: begin
          IF_ID_stall  = 1'b1;
          ID_EX_bubble = 1'b1;
          if (cnt_q <= LAT_W'(1)) begin
            // Target is valid: let the PC load it and clear PC_hazard.
            PC_update   = 1'b1;
            IF_ID_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
          end else begin
            PC_stall = 1'b1;
            cnt_d    = cnt_q - LAT_W'(1);
          end
        end

        FLUSH: begin
          IF_ID_flush = 1'b1;
          if (branch_taken) begin
            cnt_d = FLUSH_LOAD;
          end else if (cnt_q <= LAT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end

        HALTED: begin
          halted       = 1'b1;
          PC_stall     = 1'b1;
          IF_ID_stall  = 1'b1;
          ID_EX_bubble = 1'b1;
        end

        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (PC_stall),
    .count(stall_count)
  );

endmodule
